// File: rtl/mc_fork_ctrl.sv
// -----------------------------------------------------------------------------
// mc_fork_ctrl
//   Per-input-port sequencer between the input flit buffer and the switch
//   allocator. It locks the route decoded from a packet's head flit and then
//   presents each flit of the packet to the allocator. A multicast
//   fork-and-absorb packet is serialised flit by flit into a local (eject)
//   copy and then a forward copy. The forward copy of the head carries the
//   rewritten destination bitmap. A flit is popped from the buffer only after
//   every copy it needs has been granted.
//
// Ports
//   clk, rst_n     clock, synchronous active-low reset
//   buf_empty      input buffer empty
//   buf_flit       head-of-buffer flit:
//                    [65:64] type (00 single, 01 head, 10 body, 11 tail)
//                    [63]    UM_TYPE (1 = multicast, 0 = unicast)
//                    [62:7]  MDST bitmap (multicast) / [62:52] DST (unicast)
//   buf_rd         pop the buffer head (combinational, one-cycle pulse)
//   rt_port        decoder output-port index for buf_flit
//   rt_multab_en   decoder: absorb locally and forward
//   rt_addr1_rm    decoder: bitmap used on the forwarded head copy
//   sa_req         one-hot request to the switch allocator (combinational)
//   sa_gnt         same-cycle grant for sa_req
//   out_valid      registered flit valid towards the crossbar
//   out_flit       registered flit towards the crossbar
//   out_port       registered crossbar select for out_flit
//   err            sticky protocol error, cleared only by reset
// -----------------------------------------------------------------------------
module mc_fork_ctrl #(
  parameter int PORTS = 5,
  parameter int LOCAL = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             buf_empty,
  input  logic [65:0]      buf_flit,
  output logic             buf_rd,
  input  logic [2:0]       rt_port,
  input  logic             rt_multab_en,
  input  logic [55:0]      rt_addr1_rm,
  output logic [PORTS-1:0] sa_req,
  input  logic             sa_gnt,
  output logic             out_valid,
  output logic [65:0]      out_flit,
  output logic [2:0]       out_port,
  output logic             err
);

  typedef enum logic [1:0] {
    FT_SINGLE = 2'b00,
    FT_HEAD   = 2'b01,
    FT_BODY   = 2'b10,
    FT_TAIL   = 2'b11
  } flit_type_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_XMIT,
    S_NEXT
  } state_e;

  localparam logic [2:0] LOCAL_IDX = 3'(LOCAL);

  // Pending copies of the current flit: bit 0 = local copy, bit 1 = forward.
  localparam logic [1:0] PEND_FWD  = 2'b10;
  localparam logic [1:0] PEND_FORK = 2'b11;

  state_e      r_state,    w_state_nxt;
  logic [1:0]  r_pend,     w_pend_nxt;
  logic        r_fork,     w_fork_nxt;
  logic [2:0]  r_fwd_port, w_fwd_port_nxt;
  logic [55:0] r_rm,       w_rm_nxt;
  logic        r_head,     w_head_nxt;   // current flit is the packet head
  logic        r_last,     w_last_nxt;   // current flit ends the packet
  logic        r_err,      w_err_nxt;
  logic        r_out_valid;
  logic [65:0] r_out_flit;
  logic [2:0]  r_out_port;

  flit_type_e  w_ftype;
  logic [2:0]  w_target;
  logic        w_grant;
  logic        w_bad_start;
  logic [65:0] w_tx_flit;
  logic [PORTS-1:0] w_sa_req;
  logic        w_buf_rd;

  assign w_ftype  = flit_type_e'(buf_flit[65:64]);
  // The local copy always goes out before the forward copy.
  assign w_target = r_pend[0] ? LOCAL_IDX : r_fwd_port;
  // A packet may not start with body/tail, nor be multicast to nobody.
  assign w_bad_start = (w_ftype == FT_BODY) || (w_ftype == FT_TAIL) ||
                       (buf_flit[63] && (buf_flit[62:7] == 56'd0));

  // NOTE: every signal driven here gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    w_state_nxt    = r_state;
    w_pend_nxt     = r_pend;
    w_fork_nxt     = r_fork;
    w_fwd_port_nxt = r_fwd_port;
    w_rm_nxt       = r_rm;
    w_head_nxt     = r_head;
    w_last_nxt     = r_last;
    w_err_nxt      = r_err;
    w_grant        = 1'b0;
    w_buf_rd       = 1'b0;
    w_sa_req       = '0;
    w_tx_flit      = buf_flit;

    // Combinational outputs are held quiet while reset is asserted so a
    // leftover flit in the buffer cannot be popped during reset.
    if (rst_n) begin
      case (r_state)
        S_IDLE: begin
          if (!buf_empty) begin
            if (w_bad_start) begin
              w_buf_rd  = 1'b1;
              w_err_nxt = 1'b1;
            end else begin
              w_fwd_port_nxt = rt_port;
              w_fork_nxt     = rt_multab_en;
              w_rm_nxt       = rt_addr1_rm;
              w_pend_nxt     = rt_multab_en ? PEND_FORK : PEND_FWD;
              w_head_nxt     = 1'b1;
              w_last_nxt     = (w_ftype == FT_SINGLE);
              w_state_nxt    = S_XMIT;
            end
          end
        end

        S_XMIT: begin
          if (r_pend == 2'b00) begin
            w_state_nxt = S_IDLE;
          end else begin
            for (int p = 0; p < PORTS; p++) begin
              w_sa_req[p] = (w_target == 3'(p));
            end
            if (sa_gnt) begin
              w_grant    = 1'b1;
              w_pend_nxt = r_pend[0] ? {r_pend[1], 1'b0} : 2'b00;
              // Only the forward copy of a forked head gets the new bitmap.
              if (!r_pend[0] && r_fork && r_head) begin
                w_tx_flit[62:7] = r_rm;
              end
              if (w_pend_nxt == 2'b00) begin
                w_buf_rd    = 1'b1;
                w_state_nxt = r_last ? S_IDLE : S_NEXT;
              end
            end
          end
        end

        S_NEXT: begin
          if (!buf_empty) begin
            w_head_nxt  = 1'b0;
            w_state_nxt = S_XMIT;
            if ((w_ftype == FT_SINGLE) || (w_ftype == FT_HEAD)) begin
              // A new packet start inside a packet: flag it and close the
              // packet with a single copy on the locked forward route.
              w_err_nxt  = 1'b1;
              w_pend_nxt = PEND_FWD;
              w_last_nxt = 1'b1;
            end else begin
              w_pend_nxt = r_fork ? PEND_FORK : PEND_FWD;
              w_last_nxt = (w_ftype == FT_TAIL);
            end
          end
        end

        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pend      <= 2'b00;
      r_fork      <= 1'b0;
      r_fwd_port  <= 3'd0;
      r_rm        <= 56'd0;
      r_head      <= 1'b0;
      r_last      <= 1'b0;
      r_err       <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_flit  <= 66'd0;
      r_out_port  <= 3'd0;
    end else begin
      r_pend      <= w_pend_nxt;
      r_fork      <= w_fork_nxt;
      r_fwd_port  <= w_fwd_port_nxt;
      r_rm        <= w_rm_nxt;
      r_head      <= w_head_nxt;
      r_last      <= w_last_nxt;
      r_err       <= w_err_nxt;
      r_out_valid <= w_grant;
      if (w_grant) begin
        r_out_flit <= w_tx_flit;
        r_out_port <= w_target;
      end
    end
  end

  assign buf_rd    = w_buf_rd;
  assign sa_req    = w_sa_req;
  assign out_valid = r_out_valid;
  assign out_flit  = r_out_flit;
  assign out_port  = r_out_port;
  assign err       = r_err;

endmodule

// File: tb/tb_mc_fork_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mc_fork_ctrl
//   Directed bench for mc_fork_ctrl. Inputs change 1 time unit after the
//   rising edge; outputs are compared 3 time units after the edge, well away
//   from either clock edge. Expected values are written out by hand.
// -----------------------------------------------------------------------------
module tb_mc_fork_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        buf_empty;
  logic [65:0] buf_flit;
  logic        buf_rd;
  logic [2:0]  rt_port;
  logic        rt_multab_en;
  logic [55:0] rt_addr1_rm;
  logic [4:0]  sa_req;
  logic        sa_gnt;
  logic        out_valid;
  logic [65:0] out_flit;
  logic [2:0]  out_port;
  logic        err;

  int total  = 0;
  int bad    = 0;
  int rd_cnt = 0;
  int rd_base;

  always #5 clk = ~clk;

  mc_fork_ctrl #(.PORTS(5), .LOCAL(0)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .buf_empty    (buf_empty),
    .buf_flit     (buf_flit),
    .buf_rd       (buf_rd),
    .rt_port      (rt_port),
    .rt_multab_en (rt_multab_en),
    .rt_addr1_rm  (rt_addr1_rm),
    .sa_req       (sa_req),
    .sa_gnt       (sa_gnt),
    .out_valid    (out_valid),
    .out_flit     (out_flit),
    .out_port     (out_port),
    .err          (err)
  );

  // Pops are counted on the falling edge, mid-cycle.
  always @(negedge clk) if (buf_rd) rd_cnt++;

  function automatic logic [65:0] mcf(input logic [1:0] t, input logic [55:0] m,
                                      input logic [6:0] p);
    return {t, 1'b1, m, p};
  endfunction

  function automatic logic [65:0] ucf(input logic [1:0] t, input logic [10:0] d,
                                      input logic [51:0] p);
    return {t, 1'b0, d, p};
  endfunction

  task automatic check(input string tag, input logic [65:0] obs, input logic [65:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [65:0] f1, f2, f2_rw, uh, ub1, ub2, ut, h4, h4_rw, b4, t4, x;

    f1    = mcf(2'b00, 56'h1, 7'h15);
    f2    = mcf(2'b00, 56'h11, 7'h2a);
    f2_rw = mcf(2'b00, 56'h10, 7'h2a);
    uh    = ucf(2'b01, 11'd5, 52'h00000_0000_a001);
    ub1   = ucf(2'b10, 11'h7ff, 52'h12345_6789_abcd);
    ub2   = ucf(2'b10, 11'h0ab, 52'h0fedc_ba98_7654);
    ut    = ucf(2'b11, 11'h155, 52'h00000_0000_00ff);
    h4    = mcf(2'b01, 56'h11, 7'h11);
    h4_rw = mcf(2'b01, 56'h10, 7'h11);
    b4    = {2'b10, 1'b1, 56'hdead_beef_0123_45, 7'h22};
    t4    = {2'b11, 1'b0, 56'h00c0_ffee_0000_01, 7'h33};

    // ---- reset state ----
    rst_n = 1'b0; buf_empty = 1'b1; buf_flit = '0; rt_port = '0;
    rt_multab_en = 1'b0; rt_addr1_rm = '0; sa_gnt = 1'b0;
    tick(); tick(); settle();
    check("rst_buf_rd", buf_rd, 0);
    check("rst_sa_req", sa_req, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_flit", out_flit, 0);
    check("rst_out_port", out_port, 0);
    check("rst_err", err, 0);
    rst_n = 1'b1;

    // ---- multicast single flit, absorb only at LOCAL, grant tied high ----
    tick(); buf_empty = 1'b0; buf_flit = f1; rt_port = 3'd0;
    rt_multab_en = 1'b0; rt_addr1_rm = '0; sa_gnt = 1'b1; settle();
    check("t1_c0_req", sa_req, 5'b00000);
    check("t1_c0_rd", buf_rd, 0);
    tick(); settle();
    check("t1_c1_req", sa_req, 5'b00001);
    check("t1_c1_rd", buf_rd, 1);
    check("t1_c1_valid", out_valid, 0);
    tick(); buf_empty = 1'b1; settle();
    check("t1_c2_valid", out_valid, 1);
    check("t1_c2_port", out_port, 3'd0);
    check("t1_c2_flit", out_flit, f1);
    check("t1_c2_req", sa_req, 5'b00000);
    tick(); settle();
    check("t1_c3_valid", out_valid, 0);

    // ---- fork: local copy then rewritten forward copy on E ----
    rd_base = rd_cnt;
    tick(); buf_empty = 1'b0; buf_flit = f2; rt_port = 3'd2;
    rt_multab_en = 1'b1; rt_addr1_rm = 56'h10; sa_gnt = 1'b1; settle();
    tick(); settle();
    check("t2_c1_req", sa_req, 5'b00001);
    check("t2_c1_rd", buf_rd, 0);
    tick(); settle();
    check("t2_c2_req", sa_req, 5'b00100);
    check("t2_c2_rd", buf_rd, 1);
    check("t2_c2_valid", out_valid, 1);
    check("t2_c2_port", out_port, 3'd0);
    check("t2_c2_flit", out_flit, f2);
    tick(); buf_empty = 1'b1; settle();
    check("t2_c3_valid", out_valid, 1);
    check("t2_c3_port", out_port, 3'd2);
    check("t2_c3_flit", out_flit, f2_rw);
    check("t2_c3_req", sa_req, 5'b00000);
    check("t2_pops", rd_cnt - rd_base, 1);

    // ---- unicast 4-flit packet on S, grant withheld on first body ----
    rd_base = rd_cnt;
    tick(); buf_empty = 1'b0; buf_flit = uh; rt_port = 3'd3;
    rt_multab_en = 1'b0; sa_gnt = 1'b1; settle();
    tick(); settle();
    check("t3_head_req", sa_req, 5'b01000);
    check("t3_head_rd", buf_rd, 1);
    // decoder outputs for body flits are garbage and must be ignored
    tick(); buf_flit = ub1; rt_port = 3'd1; rt_multab_en = 1'b1; sa_gnt = 1'b0; settle();
    check("t3_head_out", out_flit, uh);
    check("t3_head_port", out_port, 3'd3);
    check("t3_next_req", sa_req, 5'b00000);
    for (int i = 0; i < 3; i++) begin
      tick(); settle();
      check("t3_wait_req", sa_req, 5'b01000);
      check("t3_wait_rd", buf_rd, 0);
      check("t3_wait_valid", out_valid, 0);
    end
    tick(); sa_gnt = 1'b1; settle();
    check("t3_b1_req", sa_req, 5'b01000);
    check("t3_b1_rd", buf_rd, 1);
    tick(); buf_flit = ub2; settle();
    check("t3_b1_out", out_flit, ub1);
    check("t3_b1_port", out_port, 3'd3);
    tick(); settle();
    check("t3_b2_rd", buf_rd, 1);
    tick(); buf_flit = ut; settle();
    check("t3_b2_out", out_flit, ub2);
    tick(); settle();
    check("t3_t_req", sa_req, 5'b01000);
    check("t3_t_rd", buf_rd, 1);
    tick(); buf_empty = 1'b1; settle();
    check("t3_t_out", out_flit, ut);
    check("t3_t_port", out_port, 3'd3);
    tick(); settle();
    check("t3_idle_req", sa_req, 5'b00000);
    check("t3_idle_valid", out_valid, 0);
    check("t3_pops", rd_cnt - rd_base, 4);

    // ---- forked 3-flit packet: each flit L then E, head fwd rewritten ----
    rd_base = rd_cnt;
    tick(); buf_empty = 1'b0; buf_flit = h4; rt_port = 3'd2;
    rt_multab_en = 1'b1; rt_addr1_rm = 56'h10; sa_gnt = 1'b1; settle();
    tick(); settle();
    check("t4_h_req_l", sa_req, 5'b00001);
    check("t4_h_rd_l", buf_rd, 0);
    tick(); settle();
    check("t4_h_req_f", sa_req, 5'b00100);
    check("t4_h_out_l", out_flit, h4);
    check("t4_h_port_l", out_port, 3'd0);
    tick(); buf_flit = b4; rt_multab_en = 1'b0; rt_port = 3'd4; settle();
    check("t4_h_out_f", out_flit, h4_rw);
    check("t4_h_port_f", out_port, 3'd2);
    tick(); settle();
    check("t4_b_req_l", sa_req, 5'b00001);
    check("t4_b_valid_gap", out_valid, 0);
    tick(); settle();
    check("t4_b_out_l", out_flit, b4);
    check("t4_b_port_l", out_port, 3'd0);
    tick(); buf_flit = t4; settle();
    check("t4_b_out_f", out_flit, b4);
    check("t4_b_port_f", out_port, 3'd2);
    tick(); settle();
    check("t4_t_req_l", sa_req, 5'b00001);
    tick(); settle();
    check("t4_t_req_f", sa_req, 5'b00100);
    check("t4_t_out_l", out_flit, t4);
    tick(); buf_empty = 1'b1; settle();
    check("t4_t_out_f", out_flit, t4);
    check("t4_t_port_f", out_port, 3'd2);
    check("t4_pops", rd_cnt - rd_base, 3);

    // ---- protocol errors in IDLE, then a good head ----
    tick(); buf_empty = 1'b0; buf_flit = ub1; sa_gnt = 1'b0; settle();
    check("t5_body_rd", buf_rd, 1);
    check("t5_body_req", sa_req, 5'b00000);
    check("t5_body_err_pre", err, 0);
    tick(); buf_flit = mcf(2'b01, 56'h0, 7'h01); settle();
    check("t5_err_set", err, 1);
    check("t5_zero_rd", buf_rd, 1);
    check("t5_zero_req", sa_req, 5'b00000);
    tick(); buf_empty = 1'b1; settle();
    check("t5_err_sticky", err, 1);
    check("t5_idle_req", sa_req, 5'b00000);
    x = ucf(2'b00, 11'd2, 52'h00000_0000_0777);
    tick(); buf_empty = 1'b0; buf_flit = x; rt_port = 3'd1;
    rt_multab_en = 1'b0; sa_gnt = 1'b1; settle();
    tick(); settle();
    check("t5_good_req", sa_req, 5'b00010);
    check("t5_good_rd", buf_rd, 1);
    tick(); buf_empty = 1'b1; settle();
    check("t5_good_out", out_flit, x);
    check("t5_good_port", out_port, 3'd1);
    check("t5_err_still", err, 1);

    // ---- reset while in NEXT of a unicast packet ----
    tick(); buf_empty = 1'b0; buf_flit = uh; rt_port = 3'd3; sa_gnt = 1'b1; settle();
    tick(); settle();
    check("t6_head_rd", buf_rd, 1);
    tick(); rst_n = 1'b0; buf_empty = 1'b1; settle();
    check("t6_next_valid", out_valid, 1);
    tick(); settle();
    check("t6_rst_valid", out_valid, 0);
    check("t6_rst_flit", out_flit, 0);
    check("t6_rst_port", out_port, 0);
    check("t6_rst_err", err, 0);
    check("t6_rst_req", sa_req, 5'b00000);
    check("t6_rst_rd", buf_rd, 0);
    x = ucf(2'b00, 11'd9, 52'h00000_0000_0abc);
    tick(); rst_n = 1'b1; buf_empty = 1'b0; buf_flit = x; rt_port = 3'd4; settle();
    check("t6_fresh_c0_req", sa_req, 5'b00000);
    tick(); settle();
    check("t6_fresh_req", sa_req, 5'b10000);
    check("t6_fresh_rd", buf_rd, 1);
    tick(); buf_empty = 1'b1; settle();
    check("t6_fresh_out", out_flit, x);
    check("t6_fresh_port", out_port, 3'd4);
    check("t6_fresh_valid", out_valid, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
